// File: rtl/fifo_pkg.sv
// fifo_pkg: shared state encodings, width defaults and helpers for the FIFO write side
package fifo_pkg;
  localparam int DATA_W_DEF = 8;
  typedef enum logic {ST_IDLE, ST_LOCK} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);
  assign any = |req;
  // scan offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    idx = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NUM_REQ]) idx = ID_W'((int'(ptr) + k) % NUM_REQ);
  end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin sharing of the FIFO write port
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CNT_W   = 16,
  localparam int ID_W   = clog2(NUM_REQ)
) (
  input  logic                      wclk,
  input  logic                      wrst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  output logic                      fifo_wen,
  output logic [DATA_W-1:0]         fifo_wdata,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          word_cnt
);
  state_t            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d, grant_q, grant_d, pick_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_any;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr_q),
    .any(pick_any),
    .idx(pick_idx)
  );
  assign busy       = state_q == ST_LOCK;
  assign grant_id   = grant_q;
  assign word_cnt   = cnt_q;
  assign fifo_wdata = req_data[int'(grant_q)*DATA_W +: DATA_W];
  // arbitrate in IDLE, then pass the owner's words through until its last beat is written
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    fifo_wen  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pick_any) begin
        grant_d = pick_idx;
        state_d = ST_LOCK;
      end
    end else begin
      req_ready[grant_q] = ~fifo_full;
      fifo_wen           = req_valid[grant_q] & ~fifo_full;
      if (fifo_wen) begin
        cnt_d = cnt_q + 1'b1;
        if (req_last[grant_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
    end
  end
  // state, pointer, grant and counter registers
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
